op2_fetch: RTL and testbench

Operand-2 front end for the data-processing path. Accepts one 32-bit ARM data-processing instruction per handshake, classifies its operand-2 encoding, and fetches Rm and Rs through a single synchronous register-file read port. It presents the assembled bundle (Rs, Rm, Imm24, opState) to the operand-2 shifter, holding it until the shifter side accepts it.

---
 rtl/op2_pkg.sv | 30 +++
 rtl/op2_fetch_classify.sv | 57 +++++
 rtl/op2_fetch.sv | 165 ++++++++++++++++
 tb/tb_op2_fetch.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/op2_pkg.sv
// op2_pkg: shared types and constants for the operand-2 front end.
//   op_state_e  - 4-bit operand-2 mode code presented to the shifter
//   fsm_state_e - fetch sequencer states
//   OP2_PC_IDX  - register index that aliases the program counter
package op2_pkg;

    typedef enum logic [3:0] {
        IMM_ROT = 4'd0,
        LSL_IMM = 4'd1,
        LSR_IMM = 4'd2,
        ASR_IMM = 4'd3,
        ROR_IMM = 4'd4,
        LSL_REG = 4'd5,
        LSR_REG = 4'd6,
        ASR_REG = 4'd7,
        ROR_REG = 4'd8,
        ILLEGAL = 4'd15
    } op_state_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_RM = 3'd1,
        ST_RD_RS = 3'd2,
        ST_LAST  = 3'd3,
        ST_OUT   = 3'd4
    } fsm_state_e;

    localparam logic [3:0] OP2_PC_IDX = 4'd15;

endpackage

// File: rtl/op2_fetch_classify.sv
// op2_classify: combinational operand-2 decoder.
//   instr_i     in  32  instruction word
//   op_state_o  out  4  operand-2 mode code
//   needs_rm_o  out  1  Rm must be fetched
//   needs_rs_o  out  1  Rs must be fetched (after Rm)
//   illegal_o   out  1  encoding is not an operand-2 form
//   rm_idx_o    out  4  instr[3:0]
//   rs_idx_o    out  4  instr[11:8]
module op2_classify
    import op2_pkg::*;
(
    input  logic [31:0] instr_i,
    output op_state_e   op_state_o,
    output logic        needs_rm_o,
    output logic        needs_rs_o,
    output logic        illegal_o,
    output logic [3:0]  rm_idx_o,
    output logic [3:0]  rs_idx_o
);

    logic unused_instr;
    assign unused_instr = ^{instr_i[31:26], instr_i[24:12]};

    assign rm_idx_o = instr_i[3:0];
    assign rs_idx_o = instr_i[11:8];

    always_comb begin
        op_state_o = IMM_ROT;
        needs_rm_o = 1'b0;
        needs_rs_o = 1'b0;
        illegal_o  = 1'b0;
        if (instr_i[25]) begin
            op_state_o = IMM_ROT;
        end else if (!instr_i[4]) begin
            needs_rm_o = 1'b1;
            case (instr_i[6:5])
                2'd0:    op_state_o = LSL_IMM;
                2'd1:    op_state_o = LSR_IMM;
                2'd2:    op_state_o = ASR_IMM;
                default: op_state_o = ROR_IMM;
            endcase
        end else if (!instr_i[7]) begin
            needs_rm_o = 1'b1;
            needs_rs_o = 1'b1;
            case (instr_i[6:5])
                2'd0:    op_state_o = LSL_REG;
                2'd1:    op_state_o = LSR_REG;
                2'd2:    op_state_o = ASR_REG;
                default: op_state_o = ROR_REG;
            endcase
        end else begin
            op_state_o = ILLEGAL;
            illegal_o  = 1'b1;
        end
    end

endmodule

// File: rtl/op2_fetch.sv
// op2_fetch: operand-2 front end. Accepts one instruction per handshake,
// fetches Rm (and Rs) through one synchronous register-file read port, and
// holds the assembled bundle until the shifter accepts it.
//   clk, rst_n           clock / async active-low reset
//   in_valid/in_ready    instruction handshake (ready only in IDLE)
//   instr, pc_plus8      instruction word and its PC+8, sampled on accept
//   rf_ren/raddr/rdata   register-file read port, data one cycle after ren
//   out_valid/out_ready  bundle handshake
//   Rs, Rm, Imm24, opState, illegal  bundle contents
// Build option: OP2_PC_BYPASS_EN substitutes the captured PC+8 for reads
// of r15 instead of using the register file.
//
// state    | meaning
// ST_IDLE  | waiting for an instruction, in_ready=1
// ST_RD_RM | read request for Rm
// ST_RD_RS | latch Rm, read request for Rs
// ST_LAST  | latch the final fetched operand
// ST_OUT   | bundle valid, waiting for out_ready
module op2_fetch
    import op2_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc_plus8,
    output logic        rf_ren,
    output logic [3:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Rs,
    output logic [31:0] Rm,
    output logic [23:0] Imm24,
    output logic [3:0]  opState,
    output logic        illegal
);

    fsm_state_e  state_q, state_d;
    op_state_e   op_state_q;
    logic [23:0] imm24_q;
    logic [31:0] rs_q, rm_q;
    logic [3:0]  rm_idx_q, rs_idx_q;
    logic        needs_rs_q;
    logic        illegal_q;

    op_state_e   cls_op_state;
    logic        cls_needs_rm, cls_needs_rs, cls_illegal;
    logic [3:0]  cls_rm_idx, cls_rs_idx;

    logic        accept;
    logic        rd_req;
    logic [3:0]  rd_idx;
    logic [3:0]  latch_idx;
    logic [31:0] fetch_val;

    op2_classify u_classify (
        .instr_i    (instr),
        .op_state_o (cls_op_state),
        .needs_rm_o (cls_needs_rm),
        .needs_rs_o (cls_needs_rs),
        .illegal_o  (cls_illegal),
        .rm_idx_o   (cls_rm_idx),
        .rs_idx_o   (cls_rs_idx)
    );

    // in_ready is gated by rst_n so it is low for the whole reset pulse
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_OUT);

    always_comb begin
        state_d = state_q;
        rd_req  = 1'b0;
        rd_idx  = 4'd0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = cls_needs_rm ? ST_RD_RM : ST_OUT;
            end
            ST_RD_RM: begin
                rd_req  = 1'b1;
                rd_idx  = rm_idx_q;
                state_d = needs_rs_q ? ST_RD_RS : ST_LAST;
            end
            ST_RD_RS: begin
                rd_req  = 1'b1;
                rd_idx  = rs_idx_q;
                state_d = ST_LAST;
            end
            ST_LAST: state_d = ST_OUT;
            ST_OUT: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Index whose data arrives this cycle: Rm in RD_RS, and in LAST either
    // Rs (register shift) or Rm (immediate shift).
    assign latch_idx = (state_q == ST_LAST && needs_rs_q) ? rs_idx_q : rm_idx_q;

`ifdef OP2_PC_BYPASS_EN
    logic [31:0] pc_q;

    assign rf_ren    = rd_req && (rd_idx != OP2_PC_IDX);
    assign fetch_val = (latch_idx == OP2_PC_IDX) ? pc_q : rf_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      pc_q <= '0;
        else if (accept) pc_q <= pc_plus8;
    end
`else
    logic unused_pc;
    logic unused_latch_idx;

    assign unused_pc        = ^pc_plus8;
    assign unused_latch_idx = ^latch_idx;
    assign rf_ren           = rd_req;
    assign fetch_val        = rf_rdata;
`endif

    assign rf_raddr = rf_ren ? rd_idx : 4'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_state_q <= IMM_ROT;
            imm24_q    <= '0;
            rs_q       <= '0;
            rm_q       <= '0;
            rm_idx_q   <= '0;
            rs_idx_q   <= '0;
            needs_rs_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_state_q <= cls_op_state;
                imm24_q    <= instr[23:0];
                rs_q       <= '0;
                rm_q       <= '0;
                rm_idx_q   <= cls_rm_idx;
                rs_idx_q   <= cls_rs_idx;
                needs_rs_q <= cls_needs_rs;
                illegal_q  <= cls_illegal;
            end
            if (state_q == ST_RD_RS) rm_q <= fetch_val;
            if (state_q == ST_LAST) begin
                if (needs_rs_q) rs_q <= fetch_val;
                else            rm_q <= fetch_val;
            end
        end
    end

    assign Rs      = rs_q;
    assign Rm      = rm_q;
    assign Imm24   = imm24_q;
    assign opState = op_state_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_op2_fetch.sv
module tb_op2_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc_plus8;
    logic        rf_ren;
    logic [3:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Rs;
    logic [31:0] Rm;
    logic [23:0] Imm24;
    logic [3:0]  opState;
    logic        illegal;

    int compared = 0;
    int mismatched = 0;
    int ren_cnt = 0;
    int ren_snap;

    logic [31:0] rf [16];

    always #5 clk = ~clk;

    op2_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc_plus8  (pc_plus8),
        .rf_ren    (rf_ren),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Rs        (Rs),
        .Rm        (Rm),
        .Imm24     (Imm24),
        .opState   (opState),
        .illegal   (illegal)
    );

    // synchronous read port model
    always @(posedge clk) begin
        if (rf_ren) rf_rdata <= rf[rf_raddr];
        if (rf_ren) ren_cnt  <= ren_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc);
        instr    = ins;
        pc_plus8 = pc;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_in_ready",  32'(in_ready),  32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h1000_0000 + 32'(i);
        rf[1]  = 32'h4000_0001;
        rf[2]  = 32'hDEAD_BEEF;
        rf[3]  = 32'h0000_0003;
        rf[4]  = 32'h8000_0000;
        rf[15] = 32'hAAAA_5555;
        rf_rdata  = 32'h0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'h0;
        pc_plus8  = 32'h0;

        // reset state
        #3;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rf_ren",    32'(rf_ren),    32'd0);
        chk("rst_rf_raddr",  32'(rf_raddr),  32'd0);
        chk("rst_bundle",    32'(Rs | Rm | 32'(Imm24) | 32'(opState) | 32'(illegal)), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // IMM_ROT: bundle one cycle after accept, no reads
        ren_snap = ren_cnt;
        offer(32'h0200_0105, 32'h0);
        chk("imm_out_valid", 32'(out_valid), 32'd1);
        chk("imm_opState",   32'(opState),   32'd0);
        chk("imm_Imm24",     32'(Imm24),     32'h000105);
        chk("imm_Rs",        Rs,             32'd0);
        chk("imm_Rm",        Rm,             32'd0);
        chk("imm_in_ready",  32'(in_ready),  32'd0);
        chk("imm_no_reads",  32'(ren_cnt - ren_snap), 32'd0);
        drain();

        // LSL #5, Rm=r1: read in cycle 1, bundle in cycle 3
        offer(32'h0000_0281, 32'h0);
        chk("lsl_c1_ren",   32'(rf_ren),   32'd1);
        chk("lsl_c1_raddr", 32'(rf_raddr), 32'd1);
        step();
        chk("lsl_c2_ren",   32'(rf_ren),    32'd0);
        chk("lsl_c2_raddr", 32'(rf_raddr),  32'd0);
        chk("lsl_c2_valid", 32'(out_valid), 32'd0);
        step();
        chk("lsl_c3_valid", 32'(out_valid), 32'd1);
        chk("lsl_opState",  32'(opState),   32'd1);
        chk("lsl_Rm",       Rm,             32'h4000_0001);
        chk("lsl_Rs",       Rs,             32'd0);
        chk("lsl_Imm24",    32'(Imm24),     32'h000281);
        drain();

        // ASR #1, Rm=r4
        offer(32'h0000_00C4, 32'h0);
        step();
        step();
        chk("asr_valid",   32'(out_valid), 32'd1);
        chk("asr_opState", 32'(opState),   32'd3);
        chk("asr_Rm",      Rm,             32'h8000_0000);
        drain();

        // ROR by r3, Rm=r2: reads 2 then 3, bundle in cycle 4
        offer(32'h0000_0372, 32'h0);
        chk("ror_c1_raddr", 32'(rf_raddr),  32'd2);
        step();
        chk("ror_c2_ren",   32'(rf_ren),    32'd1);
        chk("ror_c2_raddr", 32'(rf_raddr),  32'd3);
        step();
        chk("ror_c3_ren",   32'(rf_ren),    32'd0);
        chk("ror_c3_valid", 32'(out_valid), 32'd0);
        step();
        chk("ror_c4_valid", 32'(out_valid), 32'd1);
        chk("ror_opState",  32'(opState),   32'd8);
        chk("ror_Rm",       Rm,             32'hDEAD_BEEF);
        chk("ror_Rs",       Rs,             32'd3);

        // backpressure: hold OUT for 5 cycles with a competing offer
        instr    = 32'h0200_0ABC;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid",    32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready),  32'd0);
            chk("bp_Rm",       Rm,             32'hDEAD_BEEF);
            chk("bp_Imm24",    32'(Imm24),     32'h000372);
        end
        in_valid = 1'b0;
        drain();
        step();
        chk("bp_no_accept", 32'(out_valid), 32'd0);

        // illegal form
        ren_snap = ren_cnt;
        offer(32'h0000_0090, 32'h0);
        chk("ill_valid",    32'(out_valid), 32'd1);
        chk("ill_opState",  32'(opState),   32'd15);
        chk("ill_flag",     32'(illegal),   32'd1);
        chk("ill_no_reads", 32'(ren_cnt - ren_snap), 32'd0);
        drain();

        // Rm = r15, LSL #0
        ren_snap = ren_cnt;
        offer(32'h0000_000F, 32'h0000_0108);
        step();
        step();
        chk("pc_valid", 32'(out_valid), 32'd1);
`ifdef OP2_PC_BYPASS_EN
        chk("pc_Rm",       Rm, 32'h0000_0108);
        chk("pc_no_reads", 32'(ren_cnt - ren_snap), 32'd0);
`else
        chk("pc_Rm",    Rm, 32'hAAAA_5555);
        chk("pc_reads", 32'(ren_cnt - ren_snap), 32'd1);
`endif
        drain();

        // reset during RD_RS aborts the instruction
        offer(32'h0000_0372, 32'h0);
        step();
        chk("abort_in_rs", 32'(rf_raddr), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("abort_valid",    32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready),  32'd0);
        chk("abort_ren",      32'(rf_ren),    32'd0);
        chk("abort_bundle",   32'(Rs | Rm | 32'(Imm24) | 32'(opState)), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_no_stale", 32'(out_valid), 32'd0);
            chk("abort_idle",     32'(in_ready),  32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
